// File: rtl/dp_bram48_pkg.sv
// Shared sizing and state encoding for the dual-port block RAM with power-on clear.
package dp_bram48_pkg;

    localparam int unsigned DATA_W = 48;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    // StClear zeroes the array one word per cycle; StRun serves both ports.
    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

endpackage

// File: rtl/dp_bram48_core.sv
// Plain true-dual-port storage array, no reset, coded for block-RAM inference.
// Same-port read-during-write returns the new data; the other port sees the old word.
// When both ports write one address, port A's data is kept.
module dp_bram48_core #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_wdata_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    // Array writes; port A is applied last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_we_b) begin
            r_mem[i_addr_b] <= i_wdata_b;
        end
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_wdata_a;
        end
    end

    // Port A registered read, write-first on its own write.
    always_ff @(posedge i_clk) begin
        r_rdata_a <= i_we_a ? i_wdata_a : r_mem[i_addr_a];
    end

    // Port B registered read, write-first on its own write.
    always_ff @(posedge i_clk) begin
        r_rdata_b <= i_we_b ? i_wdata_b : r_mem[i_addr_b];
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/dp_bram48.sv
// Dual-port 48-bit block RAM that zeroes itself after every reset before accepting
// traffic. Owns the clear FSM, write muxing, collision flag and output valid flags.
module dp_bram48 #(
    parameter int unsigned DATA_W = dp_bram48_pkg::DATA_W,
    parameter int unsigned ADDR_W = dp_bram48_pkg::ADDR_W,
    parameter int unsigned DEPTH  = dp_bram48_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_a,
    input  logic              we_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b,
    output logic              q_valid_a,
    output logic              q_valid_b,
    output logic              ready,
    output logic              collision
);

    import dp_bram48_pkg::*;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_next;
    logic              w_ready;
    logic              w_mem_we_a;
    logic              w_mem_we_b;
    logic [ADDR_W-1:0] w_mem_addr_a;
    logic [DATA_W-1:0] w_mem_wdata_a;
    logic [DATA_W-1:0] w_core_q_a;
    logic [DATA_W-1:0] w_core_q_b;
    logic              r_q_valid;
    logic              r_collision;

    assign w_ready = (r_state == StRun);

    // State and clear-address registers; reset restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StClear;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // Next state and write-port muxing: clearing owns port A, RUN passes traffic through.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_mem_we_a      = 1'b0;
        w_mem_we_b      = 1'b0;
        w_mem_addr_a    = addr_a;
        w_mem_wdata_a   = data_a;
        unique case (r_state)
            StClear: begin
                w_mem_we_a    = !reset;
                w_mem_addr_a  = r_clr_addr;
                w_mem_wdata_a = '0;
                // Counter stops at the last word instead of wrapping.
                if (r_clr_addr == LastAddr) begin
                    w_state_next = StRun;
                end else begin
                    w_clr_addr_next = r_clr_addr + 1'b1;
                end
            end
            StRun: begin
                // Writes presented alongside reset are dropped.
                w_mem_we_a = we_a && !reset;
                w_mem_we_b = we_b && !reset;
            end
            default: ;
        endcase
    end

    // Valid trails ready by one cycle; collision flags a same-address dual write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_valid   <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_q_valid   <= w_ready;
            r_collision <= w_ready && we_a && we_b && (addr_a == addr_b);
        end
    end

    dp_bram48_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .i_clk     (clk),
        .i_we_a    (w_mem_we_a),
        .i_addr_a  (w_mem_addr_a),
        .i_wdata_a (w_mem_wdata_a),
        .i_we_b    (w_mem_we_b),
        .i_addr_b  (addr_b),
        .i_wdata_b (data_b),
        .o_rdata_a (w_core_q_a),
        .o_rdata_b (w_core_q_b)
    );

    // The array has no reset, so read data is forced to zero until it is meaningful.
    assign q_a       = r_q_valid ? w_core_q_a : '0;
    assign q_b       = r_q_valid ? w_core_q_b : '0;
    assign q_valid_a = r_q_valid;
    assign q_valid_b = r_q_valid;
    assign ready     = w_ready;
    assign collision = r_collision;

endmodule

// File: tb/tb_dp_bram48.sv
// Self-checking bench for dp_bram48: a behavioural memory model checked every cycle,
// directed scenarios with literal expectations, and randomized dual-port traffic.
module tb_dp_bram48;

    localparam int unsigned DW    = dp_bram48_pkg::DATA_W;
    localparam int unsigned AW    = dp_bram48_pkg::ADDR_W;
    localparam int unsigned DEPTH = dp_bram48_pkg::DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_a, data_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          we_a, we_b;
    logic [DW-1:0] q_a, q_b;
    logic          q_valid_a, q_valid_b, ready, collision;

    always #5 clk = ~clk;

    dp_bram48 dut (
        .clk       (clk),
        .reset     (reset),
        .data_a    (data_a),
        .data_b    (data_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .q_a       (q_a),
        .q_b       (q_b),
        .q_valid_a (q_valid_a),
        .q_valid_b (q_valid_b),
        .ready     (ready),
        .collision (collision)
    );

    // Reference model: array contents, number of words cleared since reset, expected outputs.
    logic [DW-1:0] m_mem [DEPTH];
    int unsigned   m_clr;
    logic [DW-1:0] e_qa, e_qb;
    logic          e_valid, e_ready, e_coll;
    bit            chk_en = 1'b0;
    int            n_checks = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs the DUT just sampled.
    task automatic model_edge();
        logic [DW-1:0] old_a, old_b;
        if (reset) begin
            m_clr   = 0;
            e_qa    = '0;
            e_qb    = '0;
            e_valid = 1'b0;
            e_coll  = 1'b0;
        end else if (m_clr < DEPTH) begin
            m_mem[m_clr[AW-1:0]] = '0;
            m_clr++;
            e_qa    = '0;
            e_qb    = '0;
            e_valid = 1'b0;
            e_coll  = 1'b0;
        end else begin
            old_a   = m_mem[addr_a];
            old_b   = m_mem[addr_b];
            e_qa    = we_a ? data_a : old_a;
            e_qb    = we_b ? data_b : old_b;
            e_valid = 1'b1;
            e_coll  = we_a && we_b && (addr_a == addr_b);
            if (we_b) m_mem[addr_b] = data_b;
            if (we_a) m_mem[addr_a] = data_a;
        end
        e_ready = (m_clr >= DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic rand_inputs();
        we_a   = 1'($urandom_range(0, 1));
        we_b   = 1'($urandom_range(0, 1));
        addr_a = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
        addr_b = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
        data_a = {16'($urandom), 32'($urandom)};
        data_b = {16'($urandom), 32'($urandom)};
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", DW'(ready), DW'(e_ready));
            check("q_valid_a", DW'(q_valid_a), DW'(e_valid));
            check("q_valid_b", DW'(q_valid_b), DW'(e_valid));
            check("collision", DW'(collision), DW'(e_coll));
            check("q_a", q_a, e_qa);
            check("q_b", q_b, e_qb);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        idle();
        addr_a = '0;
        addr_b = '0;
        data_a = '0;
        data_b = '0;
        tick();
        chk_en = 1'b1;
        // Writes held during reset must be dropped.
        we_a   = 1'b1;
        addr_a = 10'd5;
        data_a = 48'h1234;
        tick();
        check("rst_ready", DW'(ready), DW'(1'b0));
        check("rst_q_a", q_a, 48'd0);
        check("rst_valid_a", DW'(q_valid_a), DW'(1'b0));
        check("rst_coll", DW'(collision), DW'(1'b0));

        // Clear ignores port traffic; ready after exactly DEPTH edges.
        reset  = 1'b0;
        we_a   = 1'b1;
        addr_a = 10'd5;
        data_a = 48'd7;
        repeat (DEPTH - 1) tick();
        check("clr_ready_early", DW'(ready), DW'(1'b0));
        tick();
        check("clr_ready_on_time", DW'(ready), DW'(1'b1));
        check("clr_valid_lags", DW'(q_valid_a), DW'(1'b0));
        idle();
        addr_a = 10'd5;
        tick();
        check("clr_addr5_zero", q_a, 48'd0);
        check("clr_valid_a", DW'(q_valid_a), DW'(1'b1));

        // A writes 24 to address 2, B reads it back next cycle.
        we_a   = 1'b1;
        addr_a = 10'd2;
        data_a = 48'd24;
        tick();
        idle();
        addr_b = 10'd2;
        tick();
        check("wr_rd_q_b", q_b, 48'd24);
        check("wr_rd_valid_b", DW'(q_valid_b), DW'(1'b1));

        // Same-address dual write: A's data kept, one-cycle collision pulse.
        we_a   = 1'b1;
        addr_a = 10'd3;
        data_a = 48'hAAAA;
        we_b   = 1'b1;
        addr_b = 10'd3;
        data_b = 48'h5555;
        tick();
        check("coll_pulse", DW'(collision), DW'(1'b1));
        check("coll_q_a_own", q_a, 48'hAAAA);
        check("coll_q_b_own", q_b, 48'h5555);
        idle();
        tick();
        check("coll_drop", DW'(collision), DW'(1'b0));
        check("coll_a_wins_a", q_a, 48'hAAAA);
        check("coll_a_wins_b", q_b, 48'hAAAA);

        // Cross-port read-old vs same-port write-first.
        we_a   = 1'b1;
        addr_a = 10'd9;
        data_a = 48'd11;
        tick();
        data_a = 48'd12;
        addr_b = 10'd9;
        tick();
        check("rdw_q_a_new", q_a, 48'd12);
        check("rdw_q_b_old", q_b, 48'd11);

        // Full 48-bit word through port B.
        idle();
        we_b   = 1'b1;
        addr_b = 10'd0;
        data_b = '1;
        tick();
        idle();
        addr_a = 10'd0;
        tick();
        check("wide_q_a", q_a, 48'hFFFF_FFFF_FFFF);

        // Distinct addresses written together both commit.
        we_a   = 1'b1;
        addr_a = 10'd20;
        data_a = 48'h1111_2222_3333;
        we_b   = 1'b1;
        addr_b = 10'd21;
        data_b = 48'h4444_5555_6666;
        tick();
        idle();
        addr_a = 10'd21;
        addr_b = 10'd20;
        tick();
        check("dual_q_a", q_a, 48'h4444_5555_6666);
        check("dual_q_b", q_b, 48'h1111_2222_3333);

        // Randomized traffic, model-checked each cycle.
        repeat (2000) begin
            rand_inputs();
            tick();
        end

        // Reset part-way through a clear restarts it from zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (300) begin
            rand_inputs();
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (DEPTH - 1) begin
            rand_inputs();
            tick();
        end
        check("reclr_ready_early", DW'(ready), DW'(1'b0));
        tick();
        check("reclr_ready", DW'(ready), DW'(1'b1));
        repeat (500) begin
            rand_inputs();
            tick();
        end

        // Reset mid-RUN wipes address 1023.
        idle();
        we_a   = 1'b1;
        addr_a = 10'd1023;
        data_a = 48'hFFFF;
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("run_rst_ready", DW'(ready), DW'(1'b0));
        check("run_rst_q_a", q_a, 48'd0);
        reset = 1'b0;
        repeat (DEPTH - 1) begin
            rand_inputs();
            tick();
        end
        check("run_rst_ready_early", DW'(ready), DW'(1'b0));
        idle();
        tick();
        check("run_rst_ready_back", DW'(ready), DW'(1'b1));
        addr_a = 10'd1023;
        addr_b = 10'd1023;
        tick();
        check("run_rst_1023_a", q_a, 48'd0);
        check("run_rst_1023_b", q_b, 48'd0);
        repeat (300) begin
            rand_inputs();
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
